alu_issue: RTL and testbench
============================

# alu_issue

Front-end driver for the ALU: accepts decoded-instruction beats from the ID stage, turns ALUOp/funct into the 4-bit ALU control code and selects operand 2 (register or sign-extended immediate). It presents `src1`/`src2`/`ctrl` to the ALU through a registered, 2-entry skid-buffered valid/ready pipeline stage. It sits at the ID/EX boundary of the pipelined CPU and absorbs EX-side stalls without a combinational ready path back to ID.

## Interface
- `DATA_W`, 32: operand width.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset; one clock; reset is asynchronous and active-high.
- `flush_i`  in  1  synchronous flush; drops all held beats.
- `valid_i`  in  1  input beat valid.
- `ready_o`  out  1  stage can accept; registered.
- `alu_op_i`  in  3  ALUOp from main decoder.
- `funct_i`  in  6  instr[5:0].
- `alu_src_i`  in  1  1 selects immediate for operand 2.
- `rs_data_i`  in  DATA_W  operand 1.
- `rt_data_i`  in  DATA_W  register operand 2.
- `imm_i`  in  16  instr[15:0], sign-extended internally.
- `valid_o`  out  1  output beat valid.
- `ready_i`  in  1  EX stage accepts.
- `src1_o`  out  DATA_W  ALU operand 1.
- `src2_o`  out  DATA_W  ALU operand 2.
- `ctrl_o`  out  4  ALU control code.
- `illegal_o`  out  1  beat carries an unsupported ALUOp/funct; qualified by `valid_o`.

## Operation
- Decode of ALUOp:
  - 000 → add 0010.
  - 001 → sub 0110.
  - 011 → slt 0111.
  - 100 → or 0001.
  - 101 → and 0000.
  - 010 → R-type, decoded from funct.
  - 110, 111 → illegal.
- Decode of funct (R-type):
  - 0x20 add → 0010.
  - 0x22 sub → 0110.
  - 0x24 and → 0000.
  - 0x25 or → 0001.
  - 0x2A slt → 0111.
  - 0x27 nor → 1100.
  - 0x18 mul → 1111.
  - Any other funct → illegal.
- An illegal beat is still passed through with `ctrl_o`=0000 and `illegal_o`=1. It is never dropped.
- `src2` = `alu_src_i` ? {{16{imm_i[15]}}, imm_i} : `rt_data_i`. With `DATA_W`≠32, sign-extend to `DATA_W`.
- Storage is two entries: an output register (drives `*_o`) and a skid register.
- States:
  - EMPTY: `valid_o`=0, `ready_o`=1.
  - ONE: output register valid, `ready_o`=1.
  - TWO: output and skid valid, `ready_o`=0.
- Transitions (accept = `valid_i`&`ready_o`; take = `valid_o`&`ready_i`):
  - EMPTY + accept → ONE.
  - ONE + accept & !take → TWO; the new beat goes to skid.
  - ONE + accept & take → ONE; the new beat loads the output register.
  - ONE + take & !accept → EMPTY.
  - TWO + take → ONE; skid moves to the output register.
- Beats leave strictly in acceptance order. No beat is lost or duplicated.
- `flush_i`=1 has priority over everything: the next state is EMPTY and any beat accepted in the same cycle is discarded.
- Output fields are held stable while `valid_o`=1 and `ready_i`=0.

## Timing
- Latency: a beat accepted in cycle N is presented on `*_o` in cycle N+1 when the stage is not stalled.
- Throughput: one beat per cycle while `ready_i`=1.
- `ready_o` is a flop output and depends only on state. It has no combinational path from `ready_i` or `valid_i`.
- Reset values: `valid_o`=0, `ready_o`=1, `src1_o`=0, `src2_o`=0, `ctrl_o`=0000, `illegal_o`=0, state EMPTY, skid contents 0.
- Reset asserted mid-transfer clears all state immediately, without waiting for a clock edge. Operation resumes on the first clock edge after deassertion.
- Data registers need not be cleared on flush; only the valid bits must be.

## Structure
- Package `alu_pkg` holds:
  - ALU control code constants: AND, OR, ADD, SUB, SLT, NOR, MUL.
  - ALUOp encodings.
  - funct constants.
  - The state enum for EMPTY/ONE/TWO.
- Sub-module `alu_ctrl_dec`: purely combinational decode of `alu_op_i`/`funct_i` to ctrl and illegal. It is reused by the single-cycle datapath.
- `alu_issue` instantiates `alu_ctrl_dec` and the operand-2 mux ahead of the skid pipeline.

## Test plan
- After reset, `ready_i`=1: one beat with ALUOp=010, funct=0x22, rs=7, rt=3 → next cycle `valid_o`=1, `ctrl_o`=0110, `src1_o`=7, `src2_o`=3.
- `alu_src_i`=1, `imm_i`=0xFFFC, ALUOp=000 → `src2_o`=0xFFFFFFFC, `ctrl_o`=0010.
- `ready_i`=0 while 3 beats are offered (A, B, C) → A and B accepted, `ready_o`=0 in the cycle after B, C held off. `ready_i`=1 → output order A, B, C, each held stable during the stall.
- ALUOp=010 with funct=0x03, and ALUOp=111 → `ctrl_o`=0000, `illegal_o`=1, beat delivered.
- In state TWO, assert `flush_i` together with `valid_i`=1 → next cycle `valid_o`=0, `ready_o`=1, and no stale beat is emitted afterwards.
- Assert `rst_i` asynchronously between edges while in state ONE → `valid_o` drops to 0 before the next edge, `ready_o`=1. Back-to-back streaming of 8 beats with `ready_i`=1 → one output per cycle, in order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control path: control codes, ALUOp and funct
// encodings, and the issue-stage occupancy states.
package alu_pkg;

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlSlt = 4'b0111;
  localparam logic [3:0] CtrlNor = 4'b1100;
  localparam logic [3:0] CtrlMul = 4'b1111;

  localparam logic [2:0] AluOpAdd   = 3'b000;
  localparam logic [2:0] AluOpSub   = 3'b001;
  localparam logic [2:0] AluOpRType = 3'b010;
  localparam logic [2:0] AluOpSlt   = 3'b011;
  localparam logic [2:0] AluOpOr    = 3'b100;
  localparam logic [2:0] AluOpAnd   = 3'b101;

  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;
  localparam logic [5:0] FunctAnd = 6'h24;
  localparam logic [5:0] FunctOr  = 6'h25;
  localparam logic [5:0] FunctSlt = 6'h2A;
  localparam logic [5:0] FunctNor = 6'h27;
  localparam logic [5:0] FunctMul = 6'h18;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } issue_state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct decode to the 4-bit ALU control code.
// Unsupported encodings yield ctrl 0000 with illegal raised.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [2:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = CtrlAnd;
    illegal_o = 1'b0;
    case (alu_op_i)
      AluOpAdd: ctrl_o = CtrlAdd;
      AluOpSub: ctrl_o = CtrlSub;
      AluOpSlt: ctrl_o = CtrlSlt;
      AluOpOr:  ctrl_o = CtrlOr;
      AluOpAnd: ctrl_o = CtrlAnd;
      AluOpRType: begin
        case (funct_i)
          FunctAdd: ctrl_o = CtrlAdd;
          FunctSub: ctrl_o = CtrlSub;
          FunctAnd: ctrl_o = CtrlAnd;
          FunctOr:  ctrl_o = CtrlOr;
          FunctSlt: ctrl_o = CtrlSlt;
          FunctNor: ctrl_o = CtrlNor;
          FunctMul: ctrl_o = CtrlMul;
          default:  illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes ALU control, muxes operand 2 and presents the beat
// through a 2-entry skid buffer whose ready is a flop driven only by state.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        alu_op_i,
  input  logic [5:0]        funct_i,
  input  logic              alu_src_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [15:0]       imm_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [3:0]        ctrl_o,
  output logic              illegal_o
);

  logic [3:0]        dec_ctrl;
  logic              dec_illegal;
  logic [DATA_W-1:0] src2_mux;

  alu_ctrl_dec u_alu_ctrl_dec (
    .alu_op_i  (alu_op_i),
    .funct_i   (funct_i),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  assign src2_mux = alu_src_i ? DATA_W'($signed(imm_i)) : rt_data_i;

  issue_state_e      state_q;
  logic              valid_q, ready_q;
  logic [DATA_W-1:0] src1_q, src2_q, skid_src1_q, skid_src2_q;
  logic [3:0]        ctrl_q, skid_ctrl_q;
  logic              illegal_q, skid_illegal_q;

  logic accept, take;
  assign accept = valid_i & ready_q;
  assign take   = valid_q & ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StEmpty;
      valid_q        <= 1'b0;
      ready_q        <= 1'b1;
      src1_q         <= '0;
      src2_q         <= '0;
      ctrl_q         <= '0;
      illegal_q      <= 1'b0;
      skid_src1_q    <= '0;
      skid_src2_q    <= '0;
      skid_ctrl_q    <= '0;
      skid_illegal_q <= 1'b0;
    end else if (flush_i) begin
      // Only valid bits are dropped; stale data stays until overwritten.
      state_q <= StEmpty;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            src1_q    <= rs_data_i;
            src2_q    <= src2_mux;
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
            state_q   <= StOne;
            valid_q   <= 1'b1;
          end
        end
        StOne: begin
          if (accept && take) begin
            src1_q    <= rs_data_i;
            src2_q    <= src2_mux;
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
          end else if (accept) begin
            skid_src1_q    <= rs_data_i;
            skid_src2_q    <= src2_mux;
            skid_ctrl_q    <= dec_ctrl;
            skid_illegal_q <= dec_illegal;
            state_q        <= StTwo;
            ready_q        <= 1'b0;
          end else if (take) begin
            state_q <= StEmpty;
            valid_q <= 1'b0;
          end
        end
        StTwo: begin
          // ready_q is low here, so no new beat can arrive alongside the drain.
          if (take) begin
            src1_q    <= skid_src1_q;
            src2_q    <= skid_src2_q;
            ctrl_q    <= skid_ctrl_q;
            illegal_q <= skid_illegal_q;
            state_q   <= StOne;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= StEmpty;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign src1_o    = src1_q;
  assign src2_o    = src2_q;
  assign ctrl_o    = ctrl_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vector table plus hand-written
// stall, flush, async-reset and streaming sequences.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_o, alu_src_i, valid_o, ready_i, illegal_o;
  logic [2:0]  alu_op_i;
  logic [5:0]  funct_i;
  logic [31:0] rs_data_i, rt_data_i, src1_o, src2_o;
  logic [15:0] imm_i;
  logic [3:0]  ctrl_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue #(.DATA_W(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .alu_op_i  (alu_op_i),
    .funct_i   (funct_i),
    .alu_src_i (alu_src_i),
    .rs_data_i (rs_data_i),
    .rt_data_i (rt_data_i),
    .imm_i     (imm_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .src1_o    (src1_o),
    .src2_o    (src2_o),
    .ctrl_o    (ctrl_o),
    .illegal_o (illegal_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  funct;
    logic        src;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [31:0] exp_src2;
    logic [3:0]  exp_ctrl;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic [2:0] op, logic [5:0] funct, logic src, logic [31:0] rs,
                               logic [31:0] rt, logic [15:0] imm, logic [31:0] exp_src2,
                               logic [3:0] exp_ctrl, logic exp_ill);
    vec_t v;
    v.op = op; v.funct = funct; v.src = src; v.rs = rs; v.rt = rt; v.imm = imm;
    v.exp_src2 = exp_src2; v.exp_ctrl = exp_ctrl; v.exp_ill = exp_ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] funct, input logic src,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
    alu_op_i = op; funct_i = funct; alu_src_i = src;
    rs_data_i = rs; rt_data_i = rt; imm_i = imm;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    drive(3'b000, 6'h00, 1'b0, 32'd0, 32'd0, 16'h0000);

    vecs.push_back(mkv(3'b010, 6'h22, 1'b0, 32'd7, 32'd3, 16'h0000, 32'd3, 4'b0110, 1'b0));
    vecs.push_back(mkv(3'b000, 6'h00, 1'b1, 32'd1, 32'd9, 16'hFFFC, 32'hFFFFFFFC, 4'b0010, 1'b0));
    vecs.push_back(mkv(3'b000, 6'h03, 1'b1, 32'd2, 32'd9, 16'h7FFF, 32'h00007FFF, 4'b0010, 1'b0));
    vecs.push_back(mkv(3'b001, 6'h00, 1'b0, 32'd3, 32'h55, 16'h0000, 32'h55, 4'b0110, 1'b0));
    vecs.push_back(mkv(3'b011, 6'h00, 1'b0, 32'd4, 32'h66, 16'h0000, 32'h66, 4'b0111, 1'b0));
    vecs.push_back(mkv(3'b100, 6'h00, 1'b0, 32'd5, 32'h77, 16'h0000, 32'h77, 4'b0001, 1'b0));
    vecs.push_back(mkv(3'b101, 6'h00, 1'b0, 32'd6, 32'h88, 16'h0000, 32'h88, 4'b0000, 1'b0));
    vecs.push_back(mkv(3'b010, 6'h20, 1'b0, 32'd7, 32'h10, 16'h0000, 32'h10, 4'b0010, 1'b0));
    vecs.push_back(mkv(3'b010, 6'h24, 1'b0, 32'd8, 32'h11, 16'h0000, 32'h11, 4'b0000, 1'b0));
    vecs.push_back(mkv(3'b010, 6'h25, 1'b0, 32'd9, 32'h12, 16'h0000, 32'h12, 4'b0001, 1'b0));
    vecs.push_back(mkv(3'b010, 6'h2A, 1'b0, 32'd10, 32'h13, 16'h0000, 32'h13, 4'b0111, 1'b0));
    vecs.push_back(mkv(3'b010, 6'h27, 1'b0, 32'd11, 32'h14, 16'h0000, 32'h14, 4'b1100, 1'b0));
    vecs.push_back(mkv(3'b010, 6'h18, 1'b0, 32'd12, 32'h15, 16'h0000, 32'h15, 4'b1111, 1'b0));
    vecs.push_back(mkv(3'b010, 6'h03, 1'b0, 32'd13, 32'h16, 16'h0000, 32'h16, 4'b0000, 1'b1));
    vecs.push_back(mkv(3'b111, 6'h20, 1'b0, 32'd14, 32'h17, 16'h0000, 32'h17, 4'b0000, 1'b1));
    vecs.push_back(mkv(3'b110, 6'h20, 1'b0, 32'd15, 32'h18, 16'h0000, 32'h18, 4'b0000, 1'b1));

    #12;
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_src1", src1_o, 32'd0);
    chk("reset_src2", src2_o, 32'd0);
    chk("reset_ctrl", 32'(ctrl_o), 32'd0);
    chk("reset_illegal", 32'(illegal_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Decode table: one beat at a time, taken immediately.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].funct, vecs[i].src, vecs[i].rs, vecs[i].rt, vecs[i].imm);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'd1);
      chk($sformatf("vec%0d_src1", i), src1_o, vecs[i].rs);
      chk($sformatf("vec%0d_src2", i), src2_o, vecs[i].exp_src2);
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_o), 32'(vecs[i].exp_ctrl));
      chk($sformatf("vec%0d_illegal", i), 32'(illegal_o), 32'(vecs[i].exp_ill));
      tick();
      chk($sformatf("vec%0d_drained", i), 32'(valid_o), 32'd0);
    end

    // Stall: A, B accepted, C held off, then drained in order.
    ready_i = 1'b0;
    drive(3'b000, 6'h00, 1'b0, 32'hA, 32'hA0, 16'h0); valid_i = 1'b1;
    tick();
    chk("stall_ready_one", 32'(ready_o), 32'd1);
    chk("stall_a_src1", src1_o, 32'hA);
    drive(3'b001, 6'h00, 1'b0, 32'hB, 32'hB0, 16'h0);
    tick();
    chk("stall_ready_two", 32'(ready_o), 32'd0);
    chk("stall_a_hold1", src1_o, 32'hA);
    drive(3'b100, 6'h00, 1'b0, 32'hC, 32'hC0, 16'h0);
    tick();
    chk("stall_ready_two_b", 32'(ready_o), 32'd0);
    chk("stall_a_hold2", src1_o, 32'hA);
    chk("stall_a_hold2_src2", src2_o, 32'hA0);
    chk("stall_a_hold2_ctrl", 32'(ctrl_o), 32'h2);
    ready_i = 1'b1;
    tick();
    chk("drain_b_src1", src1_o, 32'hB);
    chk("drain_b_ctrl", 32'(ctrl_o), 32'h6);
    chk("drain_ready_back", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    chk("drain_c_src1", src1_o, 32'hC);
    chk("drain_c_ctrl", 32'(ctrl_o), 32'h1);
    chk("drain_c_valid", 32'(valid_o), 32'd1);
    tick();
    chk("drain_empty", 32'(valid_o), 32'd0);

    // Flush from TWO with a concurrent input beat.
    ready_i = 1'b0;
    drive(3'b000, 6'h00, 1'b0, 32'hD, 32'h0, 16'h0); valid_i = 1'b1;
    tick();
    drive(3'b000, 6'h00, 1'b0, 32'hE, 32'h0, 16'h0);
    tick();
    chk("flush_pre_two", 32'(ready_o), 32'd0);
    drive(3'b000, 6'h00, 1'b0, 32'hF, 32'h0, 16'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_ready", 32'(ready_o), 32'd1);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush_no_stale%0d", i), 32'(valid_o), 32'd0);
    end

    // Asynchronous reset while in ONE.
    ready_i = 1'b0;
    drive(3'b000, 6'h00, 1'b0, 32'h1234, 32'h0, 16'h0); valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("areset_pre_valid", 32'(valid_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("areset_valid", 32'(valid_o), 32'd0);
    chk("areset_ready", 32'(ready_o), 32'd1);
    chk("areset_src1", src1_o, 32'd0);
    #1 rst_i = 1'b0;
    tick();
    chk("areset_post_valid", 32'(valid_o), 32'd0);

    // Back-to-back stream of 8 beats.
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(3'b000, 6'h00, 1'b0, 32'(100 + i), 32'(200 + i), 16'h0); valid_i = 1'b1;
      tick();
      chk($sformatf("stream%0d_valid", i), 32'(valid_o), 32'd1);
      chk($sformatf("stream%0d_src1", i), src1_o, 32'(100 + i));
      chk($sformatf("stream%0d_ready", i), 32'(ready_o), 32'd1);
    end
    valid_i = 1'b0;
    tick();
    chk("stream_end", 32'(valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
